// File: rtl/hv_reg_acc_ctrl_if.sv
// Register-access bus between the SPI/OWT arbiter (master) and hv_reg_acc_ctrl (slave).
// Requests are levels; acknowledges are single-cycle pulses with echoed address and read data.
interface hv_reg_acc_ctrl_if #(
    parameter int unsigned REG_AW    = 7,
    parameter int unsigned REG_DW    = 8,
    parameter int unsigned REG_CRC_W = 8
);
    logic                 i_rac_wr_req;
    logic                 i_rac_rd_req;
    logic [REG_AW-1:0]    i_rac_addr;
    logic [REG_DW-1:0]    i_rac_wdata;
    logic [REG_CRC_W-1:0] i_rac_wcrc;
    logic                 o_rac_wack;
    logic                 o_rac_rack;
    logic [REG_DW-1:0]    o_rac_data;
    logic [REG_AW-1:0]    o_rac_addr;

    modport master (
        output i_rac_wr_req, i_rac_rd_req, i_rac_addr, i_rac_wdata, i_rac_wcrc,
        input  o_rac_wack, o_rac_rack, o_rac_data, o_rac_addr
    );

    modport slave (
        input  i_rac_wr_req, i_rac_rd_req, i_rac_addr, i_rac_wdata, i_rac_wcrc,
        output o_rac_wack, o_rac_rack, o_rac_data, o_rac_addr
    );
endinterface

// File: rtl/hv_reg_acc_ctrl.sv
// hv_reg_acc_ctrl: sequences one register-bank access per arbiter request with a fixed
// IDLE->EXEC->CAP->ACK cadence, flags CRC/address errors and keeps a saturating error count.
// Write-CRC checking is compiled in only when macro HV_RAC_CRC_CHK_EN is defined.
//
// state | meaning
// IDLE  | wait for wr/rd request, latch address/data/crc/type
// EXEC  | drive one-cycle bank strobe if access is legal
// CAP   | bank read data valid; register it with the echoed address
// ACK   | pulse wack/rack and any error flag
module hv_reg_acc_ctrl #(
    parameter int unsigned REG_AW    = 7,
    parameter int unsigned REG_DW    = 8,
    parameter int unsigned REG_CRC_W = 8,
    parameter int unsigned REG_NUM   = 96
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    hv_reg_acc_ctrl_if.slave  rac,
    output logic              o_reg_wr_en,
    output logic              o_reg_rd_en,
    output logic [REG_AW-1:0] o_reg_addr,
    output logic [REG_DW-1:0] o_reg_wdata,
    input  logic [REG_DW-1:0] i_reg_rdata,
    output logic              o_crc_err,
    output logic              o_addr_err,
    output logic [7:0]        o_err_cnt,
    input  logic              i_err_cnt_clr
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CAP, ST_ACK} state_t;

    state_t              state_q, state_d;
    logic [REG_AW-1:0]   addr_q, addr_d;
    logic [REG_DW-1:0]   wdata_q, wdata_d;
    logic                is_wr_q, is_wr_d;
    logic [REG_DW-1:0]   rac_data_q, rac_data_d;
    logic [REG_AW-1:0]   rac_addr_q, rac_addr_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic start;
    logic addr_ok;
    logic crc_ok;
    logic crc_err;
    logic addr_err;

    assign start   = (state_q == ST_IDLE) && (rac.i_rac_wr_req || rac.i_rac_rd_req);
    assign addr_ok = 32'(addr_q) < REG_NUM;

`ifdef HV_RAC_CRC_CHK_EN
    localparam int unsigned MSG_W = 8 + REG_DW;

    logic [REG_CRC_W-1:0] wcrc_q, wcrc_d;
    logic [7:0]           crc_calc;

    // Received CRC is captured together with the rest of the request
    always_comb wcrc_d = start ? rac.i_rac_wcrc : wcrc_q;

    // CRC register, cleared with the other latched request fields
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) wcrc_q <= '0;
        else          wcrc_q <= wcrc_d;
    end

    // CRC-8 (poly 0x07, init 0) over {address zero-padded to a byte, write data}, MSB first
    always_comb begin : crc8
        logic [MSG_W-1:0] msg;
        logic             fb;
        msg      = {8'(addr_q), wdata_q};
        crc_calc = 8'h00;
        for (int i = MSG_W - 1; i >= 0; i--) begin
            fb       = crc_calc[7] ^ msg[i];
            crc_calc = {crc_calc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
    end

    assign crc_ok    = (crc_calc == 8'(wcrc_q));
    assign o_crc_err = crc_err;
`else
    logic unused_wcrc;

    assign unused_wcrc = ^rac.i_rac_wcrc;
    assign crc_ok      = 1'b1;
    assign o_crc_err   = 1'b0;
`endif

    // Next-state, request latching and per-state strobes
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        is_wr_d        = is_wr_q;
        rac_data_d     = rac_data_q;
        rac_addr_d     = rac_addr_q;
        o_reg_wr_en    = 1'b0;
        o_reg_rd_en    = 1'b0;
        rac.o_rac_wack = 1'b0;
        rac.o_rac_rack = 1'b0;
        crc_err        = 1'b0;
        addr_err       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = rac.i_rac_addr;
                    wdata_d = rac.i_rac_wdata;
                    is_wr_d = rac.i_rac_wr_req;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                o_reg_wr_en = is_wr_q && crc_ok && addr_ok;
                o_reg_rd_en = !is_wr_q && addr_ok;
                state_d     = ST_CAP;
            end
            ST_CAP: begin
                rac_data_d = (!is_wr_q && addr_ok) ? i_reg_rdata : '0;
                rac_addr_d = addr_q;
                state_d    = ST_ACK;
            end
            ST_ACK: begin
                rac.o_rac_wack = is_wr_q;
                rac.o_rac_rack = !is_wr_q;
                crc_err        = is_wr_q && !crc_ok;
                addr_err       = !addr_ok && !crc_err;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Saturating error counter; clear has priority over a same-cycle error
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (i_err_cnt_clr)
            err_cnt_d = '0;
        else if ((crc_err || addr_err) && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;
    end

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_wr_q    <= 1'b0;
            rac_data_q <= '0;
            rac_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_wr_q    <= is_wr_d;
            rac_data_q <= rac_data_d;
            rac_addr_q <= rac_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign o_reg_addr     = addr_q;
    assign o_reg_wdata    = wdata_q;
    assign o_addr_err     = addr_err;
    assign o_err_cnt      = err_cnt_q;
    assign rac.o_rac_data = rac_data_q;
    assign rac.o_rac_addr = rac_addr_q;

endmodule

// File: tb/tb_hv_reg_acc_ctrl.sv
// Bench for hv_reg_acc_ctrl: directed table, randomized traffic against a transaction-level
// model, back-to-back, saturation/clear and mid-transaction reset sequences.
module tb_hv_reg_acc_ctrl;

`ifdef HV_RAC_CRC_CHK_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic       i_clk;
    logic       i_rst_n;
    logic       o_reg_wr_en, o_reg_rd_en;
    logic [6:0] o_reg_addr;
    logic [7:0] o_reg_wdata;
    logic [7:0] i_reg_rdata;
    logic       o_crc_err, o_addr_err;
    logic [7:0] o_err_cnt;
    logic       i_err_cnt_clr;

    hv_reg_acc_ctrl_if #(.REG_AW(7), .REG_DW(8), .REG_CRC_W(8)) rac_if ();

    hv_reg_acc_ctrl #(.REG_AW(7), .REG_DW(8), .REG_CRC_W(8), .REG_NUM(96)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .rac           (rac_if),
        .o_reg_wr_en   (o_reg_wr_en),
        .o_reg_rd_en   (o_reg_rd_en),
        .o_reg_addr    (o_reg_addr),
        .o_reg_wdata   (o_reg_wdata),
        .i_reg_rdata   (i_reg_rdata),
        .o_crc_err     (o_crc_err),
        .o_addr_err    (o_addr_err),
        .o_err_cnt     (o_err_cnt),
        .i_err_cnt_clr (i_err_cnt_clr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Register bank: strobes act at the rising edge, read data appears the cycle after rd_en
    logic [7:0] bank_mem [128];
    always @(posedge i_clk) begin
        if (o_reg_wr_en) bank_mem[o_reg_addr] <= o_reg_wdata;
        if (o_reg_rd_en) i_reg_rdata <= bank_mem[o_reg_addr];
    end

    typedef struct { bit wren, rden, wack, rack, crc, aerr; logic [7:0] data; } exp_t;
    typedef struct { bit wr, rd; logic [6:0] addr; logic [7:0] wdata; bit flip; exp_t e; } vec_t;
    typedef struct {
        int n_wren, n_rden, n_wack, n_rack, n_crc, n_aerr;
        int wren_cyc, rden_cyc, ack_cyc, err_cyc;
        logic [6:0] wr_addr, ack_addr, hold_addr;
        logic [7:0] wr_data, ack_data, hold_data, cnt;
    } obs_t;

    int tests = 0;
    int fails = 0;

    // Transaction-level reference state
    logic [7:0] m_mem [128];
    int         m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // CRC-8 as polynomial remainder of (message * x^8) mod x^8+x^2+x+1
    function automatic logic [7:0] crc_ref(input logic [6:0] a, input logic [7:0] d);
        logic [23:0] r;
        r = {1'b0, a, d, 8'h00};
        for (int i = 23; i >= 8; i--)
            if (r[i]) r = r ^ (24'h107 << (i - 8));
        return r[7:0];
    endfunction

    task automatic model_step(input bit wr, input logic [6:0] addr, input logic [7:0] wdata,
                              input logic [7:0] wcrc, output exp_t e);
        bit in_range, crc_ok;
        in_range = (int'(addr) < 96);
        crc_ok   = CRC_ON ? (wcrc == crc_ref(addr, wdata)) : 1'b1;
        e.wack   = wr;
        e.rack   = !wr;
        e.crc    = wr && !crc_ok;
        e.aerr   = !in_range && !e.crc;
        e.wren   = wr && in_range && crc_ok;
        e.rden   = !wr && in_range;
        e.data   = e.rden ? m_mem[addr] : 8'h00;
        if (e.wren) m_mem[addr] = wdata;
        if (e.crc || e.aerr) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    endtask

    // Drive one request at a falling edge, drop it right after sampling, observe 4 cycles
    task automatic run_txn(input bit wr, input bit rd, input logic [6:0] addr, input logic [7:0] wdata,
                           input logic [7:0] wcrc, output obs_t o);
        o = '{default: 0};
        rac_if.i_rac_wr_req = wr;
        rac_if.i_rac_rd_req = rd;
        rac_if.i_rac_addr   = addr;
        rac_if.i_rac_wdata  = wdata;
        rac_if.i_rac_wcrc   = wcrc;
        @(posedge i_clk);
        #1;
        rac_if.i_rac_wr_req = 1'b0;
        rac_if.i_rac_rd_req = 1'b0;
        rac_if.i_rac_addr   = 7'($urandom);
        rac_if.i_rac_wdata  = 8'($urandom);
        rac_if.i_rac_wcrc   = 8'($urandom);
        for (int k = 1; k <= 4; k++) begin
            @(negedge i_clk);
            if (o_reg_wr_en) begin
                o.n_wren++; o.wren_cyc = k; o.wr_addr = o_reg_addr; o.wr_data = o_reg_wdata;
            end
            if (o_reg_rd_en) begin o.n_rden++; o.rden_cyc = k; end
            if (rac_if.o_rac_wack || rac_if.o_rac_rack) begin
                o.ack_cyc = k; o.ack_data = rac_if.o_rac_data; o.ack_addr = rac_if.o_rac_addr;
            end
            if (rac_if.o_rac_wack) o.n_wack++;
            if (rac_if.o_rac_rack) o.n_rack++;
            if (o_crc_err)  begin o.n_crc++;  o.err_cyc = k; end
            if (o_addr_err) begin o.n_aerr++; o.err_cyc = k; end
            if (k == 4) begin
                o.hold_data = rac_if.o_rac_data;
                o.hold_addr = rac_if.o_rac_addr;
                o.cnt       = o_err_cnt;
            end
        end
    endtask

    task automatic do_one(input bit wr, input bit rd, input logic [6:0] addr, input logic [7:0] wdata,
                          input bit flip, output exp_t e, output obs_t o);
        logic [7:0] wcrc;
        wcrc = crc_ref(addr, wdata) ^ {7'd0, flip};
        model_step(wr, addr, wdata, wcrc, e);
        run_txn(wr, rd, addr, wdata, wcrc, o);
    endtask

    task automatic compare(input string tag, input obs_t o, input exp_t e,
                           input logic [6:0] addr, input logic [7:0] wdata);
        chk({tag, " wr_en_cnt"}, o.n_wren, e.wren);
        if (o.n_wren == 1) begin
            chk({tag, " wr_en_cyc"}, o.wren_cyc, 1);
            chk({tag, " reg_addr"}, o.wr_addr, addr);
            chk({tag, " reg_wdata"}, o.wr_data, wdata);
        end
        chk({tag, " rd_en_cnt"}, o.n_rden, e.rden);
        if (o.n_rden == 1) chk({tag, " rd_en_cyc"}, o.rden_cyc, 1);
        chk({tag, " wack_cnt"}, o.n_wack, e.wack);
        chk({tag, " rack_cnt"}, o.n_rack, e.rack);
        if (o.n_wack + o.n_rack == 1) begin
            chk({tag, " ack_cyc"}, o.ack_cyc, 3);
            chk({tag, " ack_data"}, o.ack_data, e.data);
            chk({tag, " ack_addr"}, o.ack_addr, addr);
        end
        chk({tag, " crc_err_cnt"}, o.n_crc, e.crc);
        chk({tag, " addr_err_cnt"}, o.n_aerr, e.aerr);
        if (o.n_crc + o.n_aerr > 0) chk({tag, " err_cyc"}, o.err_cyc, 3);
        chk({tag, " hold_data"}, o.hold_data, e.data);
        chk({tag, " hold_addr"}, o.hold_addr, addr);
        chk({tag, " err_cnt"}, o.cnt, m_cnt);
    endtask

    function automatic vec_t mk(bit wr, bit rd, logic [6:0] a, logic [7:0] d, bit flip,
                                bit wren, bit rden, bit crc, bit aerr, logic [7:0] data);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = a; v.wdata = d; v.flip = flip;
        v.e.wren = wren; v.e.rden = rden; v.e.wack = wr; v.e.rack = !wr;
        v.e.crc = crc; v.e.aerr = aerr; v.e.data = data;
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, " wr_en"}, o_reg_wr_en, 0);
        chk({tag, " rd_en"}, o_reg_rd_en, 0);
        chk({tag, " reg_addr"}, o_reg_addr, 0);
        chk({tag, " reg_wdata"}, o_reg_wdata, 0);
        chk({tag, " wack"}, rac_if.o_rac_wack, 0);
        chk({tag, " rack"}, rac_if.o_rac_rack, 0);
        chk({tag, " rac_data"}, rac_if.o_rac_data, 0);
        chk({tag, " rac_addr"}, rac_if.o_rac_addr, 0);
        chk({tag, " crc_err"}, o_crc_err, 0);
        chk({tag, " addr_err"}, o_addr_err, 0);
        chk({tag, " err_cnt"}, o_err_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab [13];
        exp_t e;
        obs_t o;
        int   wr_cycs[$];
        int   ack_cycs[$];
        int   n_rack;
        int   acks;
        logic [6:0] ra;
        logic [7:0] rd_data;
        bit   rw, rr, rf;

        for (int i = 0; i < 128; i++) begin
            bank_mem[i] = 8'(i) ^ 8'h4A;
            m_mem[i]    = 8'(i) ^ 8'h4A;
        end
        rac_if.i_rac_wr_req = 1'b0;
        rac_if.i_rac_rd_req = 1'b0;
        rac_if.i_rac_addr   = '0;
        rac_if.i_rac_wdata  = '0;
        rac_if.i_rac_wcrc   = '0;
        i_err_cnt_clr       = 1'b0;
        i_reg_rdata         = 8'h00;
        i_rst_n             = 1'b1;
        #2 i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        chk_all_zero("reset");
        i_rst_n = 1'b1;
        @(negedge i_clk);

        tab[0]  = mk(0, 1, 7'h10, 8'h00, 0, 0, 1, 0, 0, 8'h5A);
        tab[1]  = mk(1, 0, 7'h10, 8'hA5, 0, 1, 0, 0, 0, 8'h00);
        tab[2]  = mk(0, 1, 7'h10, 8'h00, 0, 0, 1, 0, 0, 8'hA5);
        tab[3]  = mk(1, 0, 7'h20, 8'h3C, 1, !CRC_ON, 0, CRC_ON, 0, 8'h00);
        tab[4]  = mk(0, 1, 7'h70, 8'h00, 0, 0, 0, 0, 1, 8'h00);
        tab[5]  = mk(1, 1, 7'h05, 8'h77, 0, 1, 0, 0, 0, 8'h00);
        tab[6]  = mk(0, 1, 7'h05, 8'h00, 0, 0, 1, 0, 0, 8'h77);
        tab[7]  = mk(1, 0, 7'h60, 8'h11, 0, 0, 0, 0, 1, 8'h00);
        tab[8]  = mk(1, 0, 7'h5F, 8'h99, 0, 1, 0, 0, 0, 8'h00);
        tab[9]  = mk(0, 1, 7'h5F, 8'h00, 0, 0, 1, 0, 0, 8'h99);
        tab[10] = mk(1, 0, 7'h70, 8'h22, 1, 0, 0, CRC_ON, !CRC_ON, 8'h00);
        tab[11] = mk(0, 1, 7'h20, 8'h00, 0, 0, 1, 0, 0, CRC_ON ? 8'h6A : 8'h3C);
        tab[12] = mk(0, 1, 7'h00, 8'h00, 0, 0, 1, 0, 0, 8'h4A);

        for (int i = 0; i < 13; i++) begin
            do_one(tab[i].wr, tab[i].rd, tab[i].addr, tab[i].wdata, tab[i].flip, e, o);
            compare($sformatf("tab%0d", i), o, tab[i].e, tab[i].addr, tab[i].wdata);
        end

        for (int i = 0; i < 200; i++) begin
            rw = 1'($urandom_range(0, 1));
            rr = rw ? 1'($urandom_range(0, 1)) : 1'b1;
            rf = ($urandom_range(0, 3) == 0);
            ra = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(96, 127)) : 7'($urandom_range(0, 95));
            rd_data = 8'($urandom);
            do_one(rw, rr, ra, rd_data, rf, e, o);
            compare($sformatf("rnd%0d", i), o, e, ra, rd_data);
        end

        // Both requests held high: write-only, one transaction every 4 cycles
        rac_if.i_rac_wr_req = 1'b1;
        rac_if.i_rac_rd_req = 1'b1;
        rac_if.i_rac_addr   = 7'h05;
        rac_if.i_rac_wdata  = 8'h33;
        rac_if.i_rac_wcrc   = crc_ref(7'h05, 8'h33);
        n_rack = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge i_clk);
            if (o_reg_wr_en) wr_cycs.push_back(k);
            if (rac_if.o_rac_wack) ack_cycs.push_back(k);
            if (rac_if.o_rac_rack) n_rack++;
        end
        rac_if.i_rac_wr_req = 1'b0;
        rac_if.i_rac_rd_req = 1'b0;
        for (int i = 0; i < 4; i++) model_step(1'b1, 7'h05, 8'h33, crc_ref(7'h05, 8'h33), e);
        chk("b2b wr_en_cnt", wr_cycs.size(), 4);
        chk("b2b wack_cnt", ack_cycs.size(), 4);
        chk("b2b rack_cnt", n_rack, 0);
        for (int i = 0; i < wr_cycs.size(); i++) chk($sformatf("b2b wr_en_cyc%0d", i), wr_cycs[i], 1 + 4 * i);
        for (int i = 0; i < ack_cycs.size(); i++) chk($sformatf("b2b wack_cyc%0d", i), ack_cycs[i], 3 + 4 * i);
        do_one(0, 1, 7'h05, 8'h00, 0, e, o);
        compare("b2b rd", o, e, 7'h05, 8'h00);

        // Error counter saturation
        for (int i = 0; i < 256; i++) begin
            do_one(0, 1, 7'h70, 8'h00, 0, e, o);
            compare($sformatf("sat%0d", i), o, e, 7'h70, 8'h00);
        end
        chk("sat err_cnt", o_err_cnt, 255);

        // Reset during EXEC of a write abandons it
        rac_if.i_rac_wr_req = 1'b1;
        rac_if.i_rac_addr   = 7'h30;
        rac_if.i_rac_wdata  = 8'h44;
        rac_if.i_rac_wcrc   = crc_ref(7'h30, 8'h44);
        @(posedge i_clk);
        #1 rac_if.i_rac_wr_req = 1'b0;
        @(negedge i_clk);
        chk("rst exec_wr_en", o_reg_wr_en, 1);
        i_rst_n = 1'b0;
        #1;
        chk_all_zero("rst mid");
        acks = 0;
        repeat (3) begin
            @(negedge i_clk);
            if (rac_if.o_rac_wack || rac_if.o_rac_rack) acks++;
        end
        i_rst_n = 1'b1;
        repeat (4) begin
            @(negedge i_clk);
            if (rac_if.o_rac_wack || rac_if.o_rac_rack) acks++;
        end
        chk("rst no_ack", acks, 0);
        m_cnt = 0;
        do_one(0, 1, 7'h30, 8'h00, 0, e, o);
        compare("rst after", o, e, 7'h30, 8'h00);

        // Clear beats a same-cycle increment; then a plain clear pulse
        i_err_cnt_clr = 1'b1;
        do_one(0, 1, 7'h70, 8'h00, 0, e, o);
        m_cnt = 0;
        compare("clr_win", o, e, 7'h70, 8'h00);
        i_err_cnt_clr = 1'b0;
        do_one(1, 0, 7'h7F, 8'h12, 0, e, o);
        compare("clr pre", o, e, 7'h7F, 8'h12);
        i_err_cnt_clr = 1'b1;
        @(negedge i_clk);
        i_err_cnt_clr = 1'b0;
        m_cnt = 0;
        chk("clr pulse err_cnt", o_err_cnt, m_cnt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hv_reg_acc_ctrl.md
HV_REG_ACC_CTRL -- requirements
Module: hv_reg_acc_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 7: register address width.
REQ-002 SHALL have parameter REG_DW, default 8: register data width.
REQ-003 SHALL have parameter REG_CRC_W, default 8: write CRC width.
REQ-004 SHALL have parameter REG_NUM, default 96: number of implemented registers; valid addresses are 0..REG_NUM-1.
REQ-005 SHALL have port i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports i_rac_wr_req / i_rac_rd_req  in  1 each  level write/read request from the SPI/OWT arbiter.
REQ-008 SHALL have ports i_rac_addr  in  REG_AW, i_rac_wdata  in  REG_DW, i_rac_wcrc  in  REG_CRC_W.
REQ-009 SHALL have ports o_rac_wack / o_rac_rack  out  1 each  one-cycle acknowledge pulses.
REQ-010 SHALL have ports o_rac_data  out  REG_DW  read data; o_rac_addr  out  REG_AW  echoed address of the acked transaction.
REQ-011 SHALL have ports o_reg_wr_en  out  1, o_reg_rd_en  out  1, o_reg_addr  out  REG_AW, o_reg_wdata  out  REG_DW, i_reg_rdata  in  REG_DW: register-bank access.
REQ-012 SHALL have ports o_crc_err  out  1 pulse, o_addr_err  out  1 pulse, o_err_cnt  out  8  saturating error count, i_err_cnt_clr  in  1  synchronous count clear.

Function
REQ-013 SHALL implement FSM IDLE -> EXEC -> CAP -> ACK -> IDLE, one cycle per state except IDLE.
REQ-014 SHALL in IDLE, when wr_req or rd_req is 1 at a rising edge, latch addr, wdata, wcrc and type (write if wr_req=1, else read) and move to EXEC; simultaneous wr_req and rd_req SHALL be treated as write only.
REQ-015 SHALL compute CRC-8 (poly 0x07, init 0x00, MSB first, no reflection, no final XOR) over the 16 bits {zero-pad to 8 bits of latched addr, latched wdata}.
REQ-016 SHALL in EXEC for a write with CRC match and addr < REG_NUM assert o_reg_wr_en for exactly one cycle with o_reg_addr/o_reg_wdata = latched values.
REQ-017 SHALL in EXEC for a read with addr < REG_NUM assert o_reg_rd_en for exactly one cycle; the bank returns i_reg_rdata in the following cycle (CAP), which SHALL be registered at the end of CAP.
REQ-018 SHALL in ACK pulse o_rac_wack (write) or o_rac_rack (read) for exactly one cycle, with o_rac_addr = latched addr and o_rac_data = captured read data (0 for writes); fixed latency: ack 3 cycles after the sampling edge.
REQ-019 SHALL, for a write with CRC mismatch, suppress o_reg_wr_en, pulse o_crc_err in ACK and still pulse o_rac_wack.
REQ-020 SHALL, for any access with addr >= REG_NUM, suppress bank strobes, pulse o_addr_err in ACK, return o_rac_data = 0 and still acknowledge; CRC error takes precedence (only o_crc_err pulses) when both apply.
REQ-021 SHALL increment o_err_cnt by one on each o_crc_err or o_addr_err pulse, saturating at 255; i_err_cnt_clr=1 SHALL clear it to 0, clear winning over a same-cycle increment.
REQ-022 SHALL ignore requests outside IDLE; the next request is sampled no earlier than the cycle after ACK (back-to-back: one transaction per 4 cycles).
REQ-023 SHALL complete and acknowledge a transaction even if the request drops after sampling.
REQ-024 SHALL hold o_rac_data and o_rac_addr stable from ACK until the next ACK.

Reset
REQ-025 SHALL on i_rst_n=0 immediately force FSM to IDLE, all strobes/acks/error pulses to 0, o_rac_data, o_rac_addr, o_reg_addr, o_reg_wdata, o_err_cnt and latched fields to 0; an in-flight transaction is abandoned with no ack.

Configuration
REQ-026 SHALL compile CRC checking only when macro HV_RAC_CRC_CHK_EN is defined; when undefined, every in-range write is performed, o_crc_err is tied 0, i_rac_wcrc is unused.

Verification
REQ-027 Write addr 0x10 data 0xA5 correct CRC -> o_reg_wr_en one cycle with 0x10/0xA5, o_rac_wack 3 cycles after sample, o_err_cnt unchanged.
REQ-028 Read addr 0x10, bank returns 0x5A in CAP -> o_rac_rack pulse with o_rac_data=0x5A, o_rac_addr=0x10.
REQ-029 Write addr 0x20 with CRC bit flipped -> no o_reg_wr_en, o_crc_err and o_rac_wack in ACK, o_err_cnt 0->1 (macro off: write performed, no error).
REQ-030 Read addr 0x70 (>= 96) -> no o_reg_rd_en, o_addr_err, rack with data 0; 256 such errors -> o_err_cnt stays 255; i_err_cnt_clr -> 0.
REQ-031 wr_req and rd_req both high, addr 0x05 -> write only, wack only; requests held high -> one transaction per 4 cycles.
REQ-032 Assert i_rst_n=0 during EXEC of a write -> no ack, FSM IDLE, all outputs 0; new request after release serviced normally.
